// File: rtl/alu_op_sequencer_pkg.sv
// Shared op codes, FSM state encoding and sizing for the ALU request sequencer.
package alu_op_sequencer_pkg;

  localparam int SEQ_W  = 32;
  localparam int SEQ_CW = 6;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SLT = 4'd2,
    OP_SGT = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_NOR = 4'd8,
    OP_LUI = 4'd9,
    OP_SLL = 4'd10,
    OP_SRL = 4'd11,
    OP_SRA = 4'd12,
    OP_INC = 4'd13,
    OP_DEC = 4'd14,
    OP_HAM = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_HAM_XOR  = 3'd2,
    S_HAM_LOOP = 3'd3,
    S_RESP     = 3'd4
  } seq_state_e;

  function automatic logic is_ham(input logic [3:0] op);
    return op == OP_HAM;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-drive signals of the sequencer; slave = sequencer side.
interface alu_op_sequencer_if #(
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_res;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_res;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_res,
    output req_ready, rsp_valid, rsp_res, alu_a, alu_b, alu_sel
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_res,
    input  req_ready, rsp_valid, rsp_res, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_op_sequencer_ham_iter.sv
// Hamming iterator: shift register plus set-bit counter, stepped by the parent FSM.
// Latency: one edge per load/step; no backpressure, the parent only steps while not done.
module ham_iter #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  nxt_val,
  output logic [W-1:0]  tmp,
  output logic [CW-1:0] cnt,
  output logic          done
);

  assign done = (tmp == '0);

  // nxt_val is the ALU output: the XOR on load, tmp >> 1 on step
  always_ff @(posedge clk) begin
    if (rst) begin
      tmp <= '0;
      cnt <= '0;
    end else if (load) begin
      tmp <= nxt_val;
      cnt <= '0;
    end else if (step) begin
      tmp <= nxt_val;
      cnt <= cnt + {{(CW-1){1'b0}}, tmp[0]};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU per request; op 15 runs a shift/count hamming loop.
// Latency: 2 cycles for ops 0-14, 3..35 for op 15; rsp held until rsp_ready, req_ready only in IDLE.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int W  = SEQ_W,
  parameter int CW = SEQ_CW
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);

  seq_state_e    state;
  seq_state_e    state_nxt;
  logic [3:0]    op_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  rsp_res_r;
  logic [W-1:0]  rsp_res_nxt;
  logic          rsp_load;
  logic          accept;
  logic          ham_load;
  logic          ham_step;
  logic          ham_done;
  logic [W-1:0]  ham_tmp;
  logic [CW-1:0] ham_cnt;

  assign accept        = bus.req_valid && (state == S_IDLE);
  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_res   = rsp_res_r;

  ham_iter #(.W(W), .CW(CW)) u_ham_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (ham_load),
    .step    (ham_step),
    .nxt_val (bus.alu_res),
    .tmp     (ham_tmp),
    .cnt     (ham_cnt),
    .done    (ham_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= '0;
      a_r  <= '0;
      b_r  <= '0;
    end else if (accept) begin
      op_r <= bus.req_op;
      a_r  <= bus.req_a;
      b_r  <= bus.req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           rsp_res_r <= '0;
    else if (rsp_load) rsp_res_r <= rsp_res_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    rsp_load    = 1'b0;
    rsp_res_nxt = '0;
    ham_load    = 1'b0;
    ham_step    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = is_ham(bus.req_op) ? S_HAM_XOR : S_EXEC;
      end
      S_EXEC: begin
        bus.alu_a   = a_r;
        bus.alu_b   = b_r;
        bus.alu_sel = op_r;
        rsp_load    = 1'b1;
        rsp_res_nxt = bus.alu_res;
        state_nxt   = S_RESP;
      end
      S_HAM_XOR: begin
        bus.alu_a   = a_r;
        bus.alu_b   = b_r;
        bus.alu_sel = OP_XOR;
        ham_load    = 1'b1;
        state_nxt   = S_HAM_LOOP;
      end
      S_HAM_LOOP: begin
        // ALU shifts tmp right by one; loop ends once every set bit has been shifted out
        bus.alu_a   = ham_tmp;
        bus.alu_b   = {{(W-1){1'b0}}, 1'b1};
        bus.alu_sel = OP_SRL;
        if (ham_done) begin
          rsp_load    = 1'b1;
          rsp_res_nxt = {{(W-CW){1'b0}}, ham_cnt};
          state_nxt   = S_RESP;
        end else begin
          ham_step = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
